mips_mem_bus_arbiter: RTL and testbench

- Shares the single 32-bit memory slave port between the CPU's instruction-fetch master and its data master.
- Avalon-style handshake on all three ports. A master holds its request stable while its waitrequest is high.
- Sits between mips_cpu and the RAM model. The bus testbenches drive it with 0-wait and N-wait RAMs.
- Includes a per-transaction watchdog that aborts a hung slave access and sets a sticky error flag.

---
 rtl/mips_mem_bus_arbiter_if.sv | 26 ++
 rtl/mips_mem_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_mips_mem_bus_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_mem_bus_arbiter_if.sv
// Avalon-style memory port used for the fetch, data and shared slave sides
// of mips_mem_bus_arbiter.
interface mips_mem_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = 4;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata
    );
endinterface

// File: rtl/mips_mem_bus_arbiter.sv
// Shares one memory slave between the CPU fetch and data masters, with a stall
// watchdog. Optional MIPS_ARB_ROUND_ROBIN_EN alternates grants on contention.
module mips_mem_bus_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_mem_bus_arbiter_if.slave  i_bus,
    mips_mem_bus_arbiter_if.slave  d_bus,
    mips_mem_bus_arbiter_if.master m_bus,
    output logic                   bus_error,
    output logic                   grant_d
);
    localparam int unsigned WD_W = 16;
    localparam int unsigned BE_W = 4;
    localparam logic [WD_W-1:0]   WD_LIMIT   = WD_W'(MAX_WAIT);
    localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEADBEEF);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t          state;
    logic [WD_W-1:0] wd_cnt;
    logic            wr_q;
    logic            busy_c;
    logic            abort_c;
    logic            done_c;
    logic            d_req_c;
    logic            pick_d_c;
    logic            unused_fetch_wr;

    // The fetch master is read-only; its write-side fields are never used.
    assign unused_fetch_wr = ^{i_bus.write, i_bus.byteenable, i_bus.writedata};

    assign busy_c  = (state != IDLE);
    assign abort_c = busy_c && (MAX_WAIT != 0) && (wd_cnt >= WD_LIMIT);
    assign done_c  = busy_c && (abort_c || !m_bus.waitrequest);
    assign d_req_c = d_bus.read || d_bus.write;

`ifdef MIPS_ARB_ROUND_ROBIN_EN
    logic last_d;
    assign pick_d_c = d_req_c && !(i_bus.read && last_d);
`else
    assign pick_d_c = d_req_c;
`endif

    // State, grant, watchdog and sticky error; the operation type is latched
    // at grant so a master dropping its strobe cannot cut the access short.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wd_cnt    <= '0;
            wr_q      <= 1'b0;
            bus_error <= 1'b0;
            grant_d   <= 1'b0;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
            last_d    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (pick_d_c) begin
                        state   <= BUSY_D;
                        grant_d <= 1'b1;
                        wr_q    <= d_bus.write;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
                        last_d  <= 1'b1;
`endif
                    end else if (i_bus.read) begin
                        state   <= BUSY_I;
                        grant_d <= 1'b0;
                        wr_q    <= 1'b0;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
                        last_d  <= 1'b0;
`endif
                    end
                end
                default: begin
                    if (done_c) begin
                        state   <= IDLE;
                        grant_d <= 1'b0;
                        wd_cnt  <= '0;
                        if (abort_c) begin
                            bus_error <= 1'b1;
                        end
                    end else if (m_bus.waitrequest && (wd_cnt != '1)) begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
            endcase
        end
    end

    // Slave-side mux and master completion handshakes.
    always_comb begin
        m_bus.address     = '0;
        m_bus.read        = 1'b0;
        m_bus.write       = 1'b0;
        m_bus.byteenable  = '0;
        m_bus.writedata   = '0;
        i_bus.waitrequest = 1'b1;
        i_bus.readdata    = '0;
        d_bus.waitrequest = 1'b1;
        d_bus.readdata    = '0;
        case (state)
            BUSY_I: begin
                m_bus.address    = i_bus.address;
                m_bus.read       = !abort_c;
                m_bus.byteenable = {BE_W{1'b1}};
                if (done_c) begin
                    i_bus.waitrequest = 1'b0;
                    i_bus.readdata    = abort_c ? ABORT_DATA : m_bus.readdata;
                end
            end
            BUSY_D: begin
                m_bus.address    = d_bus.address;
                m_bus.read       = !wr_q && !abort_c;
                m_bus.write      = wr_q && !abort_c;
                m_bus.byteenable = d_bus.byteenable;
                m_bus.writedata  = d_bus.writedata;
                if (done_c) begin
                    d_bus.waitrequest = 1'b0;
                    d_bus.readdata    = abort_c ? ABORT_DATA : m_bus.readdata;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mips_mem_bus_arbiter.sv
// Bench for mips_mem_bus_arbiter: table of single-master transactions plus
// contention, watchdog and reset sequences, checked through a scoreboard.
module tb_mips_mem_bus_arbiter;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MAX_WAIT  = 8;
    localparam int unsigned RAM_WORDS = 256;
    localparam int          NV        = 11;

    typedef struct {
        logic        is_d;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          waits;
        int          exp_lat;
        logic        abort;
    } vec_t;

    typedef struct {
        logic        check;
        logic [31:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic bus_error;
    logic grant_d;
    int   total = 0;
    int   bad   = 0;
    int   wait_cfg = 0;
    int   stall_cnt = 0;

    logic [31:0] ram     [RAM_WORDS];
    logic [31:0] exp_ram [RAM_WORDS];
    exp_t        i_q[$];
    exp_t        d_q[$];
    vec_t        vecs[NV];

    always #5 clk = ~clk;

    mips_mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) i_if ();
    mips_mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) d_if ();
    mips_mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_if ();

    mips_mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .i_bus     (i_if),
        .d_bus     (d_if),
        .m_bus     (m_if),
        .bus_error (bus_error),
        .grant_d   (grant_d)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hA500_0000 | 32'(i * 4);
    endfunction

    // RAM slave with wait_cfg stall cycles per access
    assign m_if.waitrequest = (m_if.read || m_if.write) && (stall_cnt < wait_cfg);
    assign m_if.readdata    = ram[m_if.address[9:2]];

    initial begin : slave
        for (int i = 0; i < RAM_WORDS; i++) ram[i] <= init_word(i);
        forever begin
            @(posedge clk);
            if ((m_if.read || m_if.write) && m_if.waitrequest) stall_cnt <= stall_cnt + 1;
            else stall_cnt <= 0;
            if (m_if.write && !m_if.waitrequest)
                for (int b = 0; b < 4; b++)
                    if (m_if.byteenable[b]) ram[m_if.address[9:2]][8*b +: 8] <= m_if.writedata[8*b +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : scoreboard
        exp_t e;
        if (rst_n) begin
            if (!i_if.waitrequest) begin
                if (i_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL i_unexpected_done: got completion expected none");
                end else begin
                    e = i_q.pop_front();
                    if (e.check) check("i_readdata", i_if.readdata, e.data);
                end
            end else check("i_idle_readdata", i_if.readdata, 32'h0);
            if (!d_if.waitrequest) begin
                if (d_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL d_unexpected_done: got completion expected none");
                end else begin
                    e = d_q.pop_front();
                    if (e.check) check("d_readdata", d_if.readdata, e.data);
                end
            end else check("d_idle_readdata", d_if.readdata, 32'h0);
        end
    end

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int   lat;
        logic done;
        exp_t e;
        wait_cfg = v.waits;
        if (v.is_d && v.wr) begin
            for (int b = 0; b < 4; b++)
                if (v.be[b]) exp_ram[v.addr[9:2]][8*b +: 8] = v.wdata[8*b +: 8];
            e.check = 1'b0; e.data = 32'h0;
            d_q.push_back(e);
        end else begin
            e.check = 1'b1;
            e.data  = v.abort ? 32'hDEADBEEF : exp_ram[v.addr[9:2]];
            if (v.is_d) d_q.push_back(e);
            else i_q.push_back(e);
        end
        if (v.is_d) begin
            d_if.address = v.addr; d_if.writedata = v.wdata; d_if.byteenable = v.be;
            d_if.read = v.rd; d_if.write = v.wr;
        end else begin
            i_if.address = v.addr; i_if.read = 1'b1;
        end
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 200) begin
            cycle();
            lat++;
            if (lat == 1) begin
                check({name, "_grant_d"}, 32'(grant_d), 32'(v.is_d));
                check({name, "_m_read"}, 32'(m_if.read), v.is_d ? 32'(v.rd && !v.wr) : 32'h1);
                check({name, "_m_write"}, 32'(m_if.write), 32'(v.is_d && v.wr));
                check({name, "_loser_wait"}, 32'(v.is_d ? i_if.waitrequest : d_if.waitrequest), 32'h1);
            end
            done = v.is_d ? !d_if.waitrequest : !i_if.waitrequest;
            if (done && v.abort) check({name, "_abort_strobe"}, 32'(m_if.read), 32'h0);
        end
        check({name, "_latency"}, 32'(lat), 32'(v.exp_lat));
        d_if.read = 1'b0; d_if.write = 1'b0; i_if.read = 1'b0;
        cycle();
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    initial begin : main
        vec_t v;
        exp_t e;
        int   got[4];
        int   exp_order[4];
        int   n;

        for (int i = 0; i < RAM_WORDS; i++) exp_ram[i] = init_word(i);
        i_if.address = 32'h0; i_if.read = 1'b0; i_if.write = 1'b0;
        i_if.byteenable = 4'h0; i_if.writedata = 32'h0;
        d_if.address = 32'h0; d_if.read = 1'b0; d_if.write = 1'b0;
        d_if.byteenable = 4'h0; d_if.writedata = 32'h0;

        vecs[0]  = '{is_d:1'b0, rd:1'b1, wr:1'b0, addr:32'h10,  wdata:32'h0,        be:4'h0, waits:0, exp_lat:1, abort:1'b0};
        vecs[1]  = '{is_d:1'b1, rd:1'b0, wr:1'b1, addr:32'h100, wdata:32'hCAFEF00D, be:4'hF, waits:0, exp_lat:1, abort:1'b0};
        vecs[2]  = '{is_d:1'b1, rd:1'b1, wr:1'b0, addr:32'h100, wdata:32'h0,        be:4'hF, waits:0, exp_lat:1, abort:1'b0};
        vecs[3]  = '{is_d:1'b1, rd:1'b1, wr:1'b0, addr:32'h40,  wdata:32'h0,        be:4'hF, waits:3, exp_lat:4, abort:1'b0};
        vecs[4]  = '{is_d:1'b1, rd:1'b0, wr:1'b1, addr:32'h44,  wdata:32'h11223344, be:4'h5, waits:1, exp_lat:2, abort:1'b0};
        vecs[5]  = '{is_d:1'b1, rd:1'b1, wr:1'b0, addr:32'h44,  wdata:32'h0,        be:4'hF, waits:2, exp_lat:3, abort:1'b0};
        vecs[6]  = '{is_d:1'b0, rd:1'b1, wr:1'b0, addr:32'h100, wdata:32'h0,        be:4'h0, waits:1, exp_lat:2, abort:1'b0};
        vecs[7]  = '{is_d:1'b0, rd:1'b1, wr:1'b0, addr:32'h3FC, wdata:32'h0,        be:4'h0, waits:0, exp_lat:1, abort:1'b0};
        vecs[8]  = '{is_d:1'b1, rd:1'b1, wr:1'b1, addr:32'h80,  wdata:32'h5A5AA5A5, be:4'hF, waits:0, exp_lat:1, abort:1'b0};
        vecs[9]  = '{is_d:1'b1, rd:1'b1, wr:1'b0, addr:32'h80,  wdata:32'h0,        be:4'hF, waits:0, exp_lat:1, abort:1'b0};
        vecs[10] = '{is_d:1'b1, rd:1'b0, wr:1'b1, addr:32'h84,  wdata:32'h77000000, be:4'h8, waits:2, exp_lat:3, abort:1'b0};

        // reset values
        #12;
        check("rst_m_read", 32'(m_if.read), 32'h0);
        check("rst_m_write", 32'(m_if.write), 32'h0);
        check("rst_m_address", m_if.address, 32'h0);
        check("rst_m_writedata", m_if.writedata, 32'h0);
        check("rst_m_byteenable", 32'(m_if.byteenable), 32'h0);
        check("rst_i_wait", 32'(i_if.waitrequest), 32'h1);
        check("rst_d_wait", 32'(d_if.waitrequest), 32'h1);
        check("rst_bus_error", 32'(bus_error), 32'h0);
        check("rst_grant_d", 32'(grant_d), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        for (int k = 0; k < NV; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        // simultaneous d_write and i_read from a fresh reset
        reset_pulse();
        wait_cfg = 0;
        for (int b = 0; b < 4; b++) exp_ram[64][8*b +: 8] = 8'(32'hCAFEF00D >> (8*b));
        e.check = 1'b0; e.data = 32'h0;   d_q.push_back(e);
        e.check = 1'b1; e.data = exp_ram[0]; i_q.push_back(e);
        d_if.address = 32'h100; d_if.writedata = 32'hCAFEF00D; d_if.byteenable = 4'hF; d_if.write = 1'b1;
        i_if.address = 32'h0; i_if.read = 1'b1;
        cycle();
        check("sim_c1_grant_d", 32'(grant_d), 32'h1);
        check("sim_c1_d_wait", 32'(d_if.waitrequest), 32'h0);
        check("sim_c1_i_wait", 32'(i_if.waitrequest), 32'h1);
        d_if.write = 1'b0;
        cycle();
        check("sim_c2_i_wait", 32'(i_if.waitrequest), 32'h1);
        check("sim_c2_d_wait", 32'(d_if.waitrequest), 32'h1);
        cycle();
        check("sim_c3_i_wait", 32'(i_if.waitrequest), 32'h0);
        check("sim_c3_grant_d", 32'(grant_d), 32'h0);
        i_if.read = 1'b0;
        cycle();
        check("sim_ram_100", ram[64], exp_ram[64]);

        // both masters requesting back-to-back
`ifdef MIPS_ARB_ROUND_ROBIN_EN
        exp_order = '{1, 0, 1, 0};
`else
        exp_order = '{1, 1, 1, 1};
`endif
        for (int k = 0; k < 4; k++) begin
            e.check = 1'b1;
            if (exp_order[k] == 1) begin e.data = exp_ram[8]; d_q.push_back(e); end
            else begin e.data = exp_ram[9]; i_q.push_back(e); end
        end
        d_if.address = 32'h20; d_if.byteenable = 4'hF; d_if.read = 1'b1;
        i_if.address = 32'h24; i_if.read = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            cycle();
            if (!d_if.waitrequest && n < 4) begin got[n] = 1; n++; end
            if (!i_if.waitrequest && n < 4) begin got[n] = 0; n++; end
        end
        d_if.read = 1'b0; i_if.read = 1'b0;
        check("rr_count", 32'(n), 32'h4);
        for (int k = 0; k < n; k++) check($sformatf("rr_order%0d", k), 32'(got[k]), 32'(exp_order[k]));
        cycle();
        cycle();
        check("rr_i_q_empty", 32'(i_q.size()), 32'h0);
        check("rr_d_q_empty", 32'(d_q.size()), 32'h0);

        // watchdog abort against a stuck slave; error flag is sticky
        check("wd_pre_bus_error", 32'(bus_error), 32'h0);
        v = '{is_d:1'b1, rd:1'b1, wr:1'b0, addr:32'h40, wdata:32'h0, be:4'hF, waits:1000, exp_lat:9, abort:1'b1};
        run_vec(v, "wd_abort");
        check("wd_bus_error", 32'(bus_error), 32'h1);
        v = '{is_d:1'b0, rd:1'b1, wr:1'b0, addr:32'h10, wdata:32'h0, be:4'h0, waits:0, exp_lat:1, abort:1'b0};
        run_vec(v, "wd_after");
        check("wd_sticky", 32'(bus_error), 32'h1);

        // reset during a stalled fetch
        wait_cfg = 1000;
        i_if.address = 32'h30; i_if.read = 1'b1;
        cycle();
        check("mrst_m_read_busy", 32'(m_if.read), 32'h1);
        cycle();
        #2 rst_n = 1'b0;
        #1;
        check("mrst_m_read", 32'(m_if.read), 32'h0);
        check("mrst_i_wait", 32'(i_if.waitrequest), 32'h1);
        check("mrst_bus_error", 32'(bus_error), 32'h0);
        check("mrst_grant_d", 32'(grant_d), 32'h0);
        i_if.read = 1'b0;
        cycle();
        check("mrst_hold_i_wait", 32'(i_if.waitrequest), 32'h1);
        rst_n = 1'b1;
        cycle();
        check("mrst_post_i_wait", 32'(i_if.waitrequest), 32'h1);
        check("mrst_post_m_read", 32'(m_if.read), 32'h0);
        v = '{is_d:1'b1, rd:1'b1, wr:1'b0, addr:32'h100, wdata:32'h0, be:4'hF, waits:2, exp_lat:3, abort:1'b0};
        run_vec(v, "post_rst");
        check("post_rst_bus_error", 32'(bus_error), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
